// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: PC mux selects, FSM states and counter width.
package fetch_pkg;

    typedef logic [2:0] pc_sel_t;

    localparam pc_sel_t PC_SEL_RESET = 3'd0;
    localparam pc_sel_t PC_SEL_HOLD  = 3'd1;
    localparam pc_sel_t PC_SEL_PLUS4 = 3'd2;
    localparam pc_sel_t PC_SEL_ALU   = 3'd3;
    localparam pc_sel_t PC_SEL_JUMP  = 3'd4;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_BOOT = 2'd1,
        S_RUN  = 2'd2
    } fetch_state_e;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the pipeline (master) and the fetch sequencer (slave), incl. perf-counter MMIO.
interface fetch_ctrl_if #(parameter int CNT_W = fetch_pkg::CNT_W_DEF);
    logic             stall_req;
    logic             br_taken;
    logic             is_jalr;
    logic             is_jal;
    logic             cnt_clr;
    logic [2:0]       pc_sel;
    logic             should_br;
    logic             fetch_valid;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output stall_req, br_taken, is_jalr, is_jal, cnt_clr,
        input  pc_sel, should_br, fetch_valid, cycle_cnt, instr_cnt
    );

    modport slave (
        input  stall_req, br_taken, is_jalr, is_jal, cnt_clr,
        output pc_sel, should_br, fetch_valid, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/perf_counter.sv
// Wrapping up-counter with synchronous reset; clear beats increment.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot sequencing, redirect/JAL/stall PC-mux selection and perf counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int BOOT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [3:0]   boot_cnt_q;
    logic [3:0]   boot_cnt_d;

    pc_sel_t pc_sel;
    logic    should_br;
    logic    fetch_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RST;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            S_RST: begin
                state_d    = S_BOOT;
                boot_cnt_d = 4'(BOOT_CYCLES - 1);
            end
            S_BOOT: begin
                if (boot_cnt_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 4'd1;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_RST;
        endcase
    end

    // Reset values are forced combinationally so rst=1 takes effect before the state register catches up.
    always_comb begin
        pc_sel      = PC_SEL_RESET;
        should_br   = 1'b1;
        fetch_valid = 1'b0;
        if (!rst && state_q == S_RUN) begin
            if (bus.stall_req) begin
                pc_sel    = PC_SEL_HOLD;
                should_br = 1'b0;
            end else if (bus.br_taken || bus.is_jalr) begin
                pc_sel    = PC_SEL_ALU;
                should_br = 1'b1;
            end else if (bus.is_jal) begin
                pc_sel      = PC_SEL_JUMP;
                should_br   = 1'b0;
                fetch_valid = 1'b1;
            end else begin
                pc_sel      = PC_SEL_PLUS4;
                should_br   = 1'b0;
                fetch_valid = 1'b1;
            end
        end
    end

    assign bus.pc_sel      = pc_sel;
    assign bus.should_br   = should_br;
    assign bus.fetch_valid = fetch_valid;

    perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .en  (1'b1),
        .q   (bus.cycle_cnt)
    );

    perf_counter #(.W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .en  (fetch_valid),
        .q   (bus.instr_cnt)
    );

endmodule
